// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates NUM_REQ byte producers onto one uart_tx serializer.
// Exactly one byte is in flight: grant -> one-cycle load strobe -> wait for the
// serializer's busy flag to rise and then fall -> next grant.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index always wins). The default build is round-robin.

// uart.vh normally supplies the byte width; fall back to 8 so the block
// elaborates on its own.
`ifndef UART_DATA_LENGTH
`define UART_DATA_LENGTH 8
`endif

module uart_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int W         = `UART_DATA_LENGTH,
  parameter int START_TMO = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ*W-1:0]       req_data_i,
  input  logic [NUM_REQ-1:0]         req_v_i,
  output logic [NUM_REQ-1:0]         req_rdy_o,
  output logic [W-1:0]               tx_data_o,
  output logic                       tx_v_o,
  input  logic                       tx_busy_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       err_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [3:0] TMO_LAST = 4'(START_TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_START,
    ST_WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    tmo_cnt;
  logic          tmo_fire;
  logic [GW-1:0] winner;
  logic          do_grant;

  // A grant needs an idle arbiter, an idle serializer and at least one request.
  // The busy guard also covers a frame still shifting out after an arbiter reset.
  assign do_grant = (state == ST_IDLE) && !tx_busy_i && (|req_v_i);

`ifdef UART_TX_ARB_FIXED_PRIO_EN

  // Fixed priority: scanning downward leaves the lowest asserted index as winner.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_v_i[i]) winner = GW'(i);
    end
  end

`else

  logic [GW-1:0] rr_ptr;
  logic [GW:0]   rr_idx;
  logic          found;

  // Round-robin search: first asserted request after the last winner, wrapping.
  // NOTE: every variable written in an always_comb gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (rr_idx >= (GW+1)'(NUM_REQ)) rr_idx = rr_idx - (GW+1)'(NUM_REQ);
      if (!found && req_v_i[rr_idx[GW-1:0]]) begin
        winner = rr_idx[GW-1:0];
        found  = 1'b1;
      end
    end
  end

  // Pointer remembers the last winner; reset value makes requester 0 win first.
  always_ff @(posedge clk_i) begin
    if (rst_i)         rr_ptr <= GW'(NUM_REQ - 1);
    else if (do_grant) rr_ptr <= winner;
  end

`endif

  // Ready goes only to the winner, and only in the cycle the grant happens.
  always_comb begin
    req_rdy_o = '0;
    if (do_grant) req_rdy_o[winner] = 1'b1;
  end

  // Next-state logic, including the start-of-frame timeout.
  always_comb begin
    state_next = state;
    tmo_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (do_grant) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_busy_i) begin
          state_next = ST_WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          // Serializer never picked up the byte: flag it and drop the byte.
          tmo_fire   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and the count of idle-busy cycles spent in WAIT_START.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_WAIT_START && !tx_busy_i && !tmo_fire) tmo_cnt <= tmo_cnt + 4'd1;
      else                                                    tmo_cnt <= '0;
    end
  end

  // Output registers: byte and index captured on the grant edge and held until
  // the next grant; the strobe is high exactly while in LOAD; the fault is sticky.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_data_o <= '0;
      tx_v_o    <= 1'b0;
      grant_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      tx_v_o <= do_grant;
      if (do_grant) begin
        tx_data_o <= req_data_i[winner*W +: W];
        grant_o   <= winner;
      end
      if (tmo_fire) err_o <= 1'b1;
    end
  end

  // Output sanity properties.
  rdy_onehot: assert property (@(posedge clk_i) $onehot0(req_rdy_o));
  strobe_single: assert property (@(posedge clk_i) disable iff (rst_i) tx_v_o |=> !tx_v_o);

endmodule
